// File: rtl/serial_bitwise_if.sv
// Handshake bundle for serial_bitwise_unit: operand/op request channel,
// serial bit stream, held result channel and status (busy, err).
interface serial_bitwise_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             bit_out;
  logic             bit_valid;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             err;
  logic             busy;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, bit_out, bit_valid,
    input  out_valid, result, err, busy
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, bit_out, bit_valid,
    output out_valid, result, err, busy
  );
endinterface

// File: rtl/serial_bitwise_unit.sv
// Bit-serial AND/OR/NAND/NOR(/XOR/XNOR) unit, one bit per clock, LSB first.
// Ports: clk, rst (sync, active-high), bus (serial_bitwise_if.slave):
//   in_valid/in_ready/a/b/op request, bit_out/bit_valid serial stream,
//   out_valid/out_ready/result/err held result, busy status.
// Macro SERIAL_BITWISE_XOR_EN enables op 4 (XOR) and op 5 (XNOR);
// without it those ops are reported as reserved (err=1, result=0).
module serial_bitwise_unit #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic clk,
  input  logic rst,
  serial_bitwise_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             err_q, err_d;
  logic             cur_bit;

  function automatic logic op_legal(
    input logic [2:0] o
  );
`ifdef SERIAL_BITWISE_XOR_EN
    return o <= 3'd5;
`else
    return o <= 3'd3;
`endif
  endfunction

  function automatic logic eval(
    input logic [2:0] o,
    input logic       x,
    input logic       y
  );
    logic r;
    r = 1'b0;
    unique case (o)
      3'd0:    r = x & y;
      3'd1:    r = x | y;
      3'd2:    r = ~(x & y);
      3'd3:    r = ~(x | y);
      3'd4:    r = x ^ y;
      3'd5:    r = ~(x ^ y);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Operands shift right each RUN cycle, so bit k is always at [0].
  always_comb begin
    cur_bit = eval(op_q, a_q[0], b_q[0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d   = bus.a;
          b_d   = bus.b;
          op_d  = bus.op;
          cnt_d = '0;
          res_d = '0;
          err_d = !op_legal(bus.op);
          state_d = op_legal(bus.op) ? RUN : DONE;
        end
      end
      RUN: begin
        a_d = a_q >> 1;
        b_d = b_q >> 1;
        for (int i = 0; i < WIDTH; i++) begin
          if (cnt_q == CNT_W'(i)) begin
            res_d[i] = cur_bit;
          end
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.bit_valid = (state_q == RUN);
    bus.bit_out   = (state_q == RUN) & cur_bit;
    bus.out_valid = (state_q == DONE);
    bus.busy      = (state_q == RUN) | (state_q == DONE);
    bus.result    = res_q;
    bus.err       = err_q;
  end

endmodule

// File: tb/tb_serial_bitwise_unit.sv
// Directed bench for serial_bitwise_unit, WIDTH=8 and WIDTH=1 instances.
module tb_serial_bitwise_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_bitwise_if #(.WIDTH(8)) bus8 ();
  serial_bitwise_if #(.WIDTH(1)) bus1 ();

  serial_bitwise_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk),
    .rst(rst),
    .bus(bus8)
  );

  serial_bitwise_unit #(.WIDTH(1)) u_dut1 (
    .clk(clk),
    .rst(rst),
    .bus(bus1)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept at cycle 0; bit k checked at cycle 1+k; DONE at WIDTH+1.
  task automatic run8(
    input string      tag,
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [2:0] op,
    input logic [7:0] exp,
    input logic       scramble
  );
    bus8.a        = a;
    bus8.b        = b;
    bus8.op       = op;
    bus8.in_valid = 1'b1;
    step();
    bus8.in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk({tag, "_bv"}, 32'(bus8.bit_valid), 32'd1);
      chk({tag, "_bit"}, 32'(bus8.bit_out), 32'(exp[k]));
      chk({tag, "_rdy"}, 32'(bus8.in_ready), 32'd0);
      if (scramble) begin
        bus8.a = ~a;
        bus8.b = ~b;
      end
      step();
    end
    chk({tag, "_ov"}, 32'(bus8.out_valid), 32'd1);
    chk({tag, "_res"}, 32'(bus8.result), 32'(exp));
    chk({tag, "_err"}, 32'(bus8.err), 32'd0);
  endtask

  task automatic release8(input string tag);
    bus8.out_ready = 1'b1;
    step();
    bus8.out_ready = 1'b0;
    chk({tag, "_idle"}, 32'(bus8.in_ready), 32'd1);
    chk({tag, "_ovlo"}, 32'(bus8.out_valid), 32'd0);
  endtask

  task automatic reserved8(
    input string      tag,
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [2:0] op
  );
    bus8.a        = a;
    bus8.b        = b;
    bus8.op       = op;
    bus8.in_valid = 1'b1;
    step();
    bus8.in_valid = 1'b0;
    chk({tag, "_ov"}, 32'(bus8.out_valid), 32'd1);
    chk({tag, "_err"}, 32'(bus8.err), 32'd1);
    chk({tag, "_res"}, 32'(bus8.result), 32'h00);
    chk({tag, "_bv"}, 32'(bus8.bit_valid), 32'd0);
    release8(tag);
  endtask

  initial begin
    bus8.in_valid  = 1'b0;
    bus8.a         = '0;
    bus8.b         = '0;
    bus8.op        = '0;
    bus8.out_ready = 1'b0;
    bus1.in_valid  = 1'b0;
    bus1.a         = '0;
    bus1.b         = '0;
    bus1.op        = '0;
    bus1.out_ready = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    chk("rst_rdy", 32'(bus8.in_ready), 32'd1);
    chk("rst_ov", 32'(bus8.out_valid), 32'd0);
    chk("rst_busy", 32'(bus8.busy), 32'd0);
    chk("rst_bv", 32'(bus8.bit_valid), 32'd0);
    chk("rst_bit", 32'(bus8.bit_out), 32'd0);
    chk("rst_err", 32'(bus8.err), 32'd0);
    chk("rst_res", 32'(bus8.result), 32'd0);

    // AND F0 & 3C = 30
    run8("and", 8'hF0, 8'h3C, 3'd0, 8'h30, 1'b0);
    release8("and");

    // NOR ~(0F | 11) = E0, held under backpressure
    run8("nor", 8'h0F, 8'h11, 3'd3, 8'hE0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_ov", 32'(bus8.out_valid), 32'd1);
      chk("bp_res", 32'(bus8.result), 32'hE0);
      chk("bp_rdy", 32'(bus8.in_ready), 32'd0);
      chk("bp_busy", 32'(bus8.busy), 32'd1);
    end
    release8("nor");

    reserved8("rsv7", 8'h12, 8'h34, 3'd7);
    reserved8("rsv6", 8'hFF, 8'hFF, 3'd6);

`ifdef SERIAL_BITWISE_XOR_EN
    run8("xor", 8'hAA, 8'hFF, 3'd4, 8'h55, 1'b0);
    release8("xor");
    run8("xnor", 8'hAA, 8'hFF, 3'd5, 8'hAA, 1'b0);
    release8("xnor");
`else
    reserved8("xor", 8'hAA, 8'hFF, 3'd4);
    reserved8("xnor", 8'hAA, 8'hFF, 3'd5);
`endif

    // OR 0x55|0x0A interrupted by reset at cycle 4
    bus8.a        = 8'h55;
    bus8.b        = 8'h0A;
    bus8.op       = 3'd1;
    bus8.in_valid = 1'b1;
    step();
    bus8.in_valid = 1'b0;
    step();
    step();
    step();
    chk("mid_busy", 32'(bus8.busy), 32'd1);
    chk("mid_part", 32'(bus8.result), 32'h07);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_rdy", 32'(bus8.in_ready), 32'd1);
    chk("mrst_busy", 32'(bus8.busy), 32'd0);
    chk("mrst_ov", 32'(bus8.out_valid), 32'd0);
    chk("mrst_res", 32'(bus8.result), 32'd0);
    run8("nand", 8'hFF, 8'h0F, 3'd2, 8'hF0, 1'b0);
    release8("nand");

    // OR 81|02 = 83 with a/b flipped during RUN
    run8("hold", 8'h81, 8'h02, 3'd1, 8'h83, 1'b1);
    release8("hold");

    // WIDTH=1: NAND 1,1 -> 0 then AND 1,1 -> 1
    bus1.a        = 1'b1;
    bus1.b        = 1'b1;
    bus1.op       = 3'd2;
    bus1.in_valid = 1'b1;
    step();
    bus1.in_valid = 1'b0;
    chk("w1_bv", 32'(bus1.bit_valid), 32'd1);
    chk("w1_bit", 32'(bus1.bit_out), 32'd0);
    chk("w1_ov1", 32'(bus1.out_valid), 32'd0);
    step();
    chk("w1_ov", 32'(bus1.out_valid), 32'd1);
    chk("w1_res", 32'(bus1.result), 32'd0);
    chk("w1_err", 32'(bus1.err), 32'd0);
    bus1.out_ready = 1'b1;
    step();
    bus1.out_ready = 1'b0;
    chk("w1_idle", 32'(bus1.in_ready), 32'd1);

    bus1.op       = 3'd0;
    bus1.in_valid = 1'b1;
    step();
    bus1.in_valid = 1'b0;
    chk("w1a_bit", 32'(bus1.bit_out), 32'd1);
    step();
    chk("w1a_ov", 32'(bus1.out_valid), 32'd1);
    chk("w1a_res", 32'(bus1.result), 32'd1);
    bus1.out_ready = 1'b1;
    step();
    bus1.out_ready = 1'b0;
    chk("w1a_idle", 32'(bus1.in_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
